// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types and constants: the NOP encoding, the fetch FSM
// states and the IF/ID pipeline register layout.
package rv32_pkg;

    localparam logic [31:0] RV32_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // A bubble carries addi x0,x0,0 with zeroed PCs so decode sees a clean no-op.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc    = 32'h0000_0000;
        b.pc4   = 32'h0000_0000;
        b.instr = RV32_NOP;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/rv32_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls and the
// IF/ID outputs toward decode. master = fetch stage, slave = surrounding core.
interface rv32_fetch_stage_if #(
    parameter int unsigned IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [31:0]        fetch_pc;
    logic [31:0]        if_id_pc;
    logic [31:0]        if_id_pc4;
    logic [31:0]        if_id_instr;
    logic               if_id_valid;
    logic               halted;
    logic               misalign_err;

    modport master (
        output imem_addr, fetch_pc, if_id_pc, if_id_pc4, if_id_instr,
               if_id_valid, halted, misalign_err,
        input  imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, fetch_pc, if_id_pc, if_id_pc4, if_id_instr,
               if_id_valid, halted, misalign_err,
        output imem_data, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise holds.
// Async reset leaves a bubble so decode never sees a stale instruction.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);
    if_id_t q_r;

    // IF/ID storage with bubble/load/hold selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= if_id_bubble();
        end else if (bubble) begin
            q_r <= if_id_bubble();
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 IF stage: PC register, next-PC selection and the RUN/HALT fetch FSM.
// Redirect beats stall beats advance; running off the end of imem halts fetch.
module rv32_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    rv32_fetch_stage_if.master bus
);
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic [31:0]  pc_plus4_s;
    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic         misalign_r;
    logic         misalign_set_s;
    logic         out_of_range_s;
    logic         load_s;
    logic         bubble_s;
    if_id_t       if_id_d_s;
    if_id_t       if_id_q_s;

    assign pc_plus4_s     = pc_r + 32'd4;
    // Any PC bit above the imem word range means the fetch would alias.
    assign out_of_range_s = |pc_r[31:IMEM_AW+2];
    assign misalign_set_s = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

    assign if_id_d_s.pc    = pc_r;
    assign if_id_d_s.pc4   = pc_plus4_s;
    assign if_id_d_s.instr = bus.imem_data;
    assign if_id_d_s.valid = 1'b1;

    // Next-PC, next-state and IF/ID control selection
    always_comb begin
        pc_next_s    = pc_r;
        state_next_s = state_r;
        load_s       = 1'b0;
        bubble_s     = 1'b0;
        if (bus.redirect) begin
            pc_next_s    = {bus.redirect_pc[31:2], 2'b00};
            state_next_s = FETCH_RUN;
            bubble_s     = 1'b1;
        end else if (bus.stall) begin
            pc_next_s    = pc_r;
            state_next_s = state_r;
        end else begin
            case (state_r)
                FETCH_RUN: begin
                    if (out_of_range_s) begin
                        bubble_s     = 1'b1;
                        state_next_s = FETCH_HALT;
                    end else begin
                        load_s    = 1'b1;
                        pc_next_s = pc_plus4_s;
                    end
                end
                FETCH_HALT: begin
                    bubble_s = 1'b1;
                end
                default: begin
                    bubble_s     = 1'b1;
                    state_next_s = FETCH_HALT;
                end
            endcase
        end
    end

    // PC, fetch FSM and sticky misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            state_r    <= FETCH_RUN;
            misalign_r <= 1'b0;
        end else begin
            pc_r       <= pc_next_s;
            state_r    <= state_next_s;
            misalign_r <= misalign_r | misalign_set_s;
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .bubble (bubble_s),
        .d      (if_id_d_s),
        .q      (if_id_q_s)
    );

    assign bus.imem_addr    = pc_r[IMEM_AW+1:2];
    assign bus.fetch_pc     = pc_r;
    assign bus.if_id_pc     = if_id_q_s.pc;
    assign bus.if_id_pc4    = if_id_q_s.pc4;
    assign bus.if_id_instr  = if_id_q_s.instr;
    assign bus.if_id_valid  = if_id_q_s.valid;
    assign bus.halted       = (state_r == FETCH_HALT);
    assign bus.misalign_err = misalign_r;
endmodule

// File: doc/rv32_fetch_stage.md
# rv32_fetch_stage

IF stage of the pipelined RV32 core: holds the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register for decode. Accepts stall requests from the hazard unit and PC redirects (taken branch/jump) from EX. Inserts NOP bubbles on redirect and on fetch beyond the end of instruction memory.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `IMEM_AW`, 6, instruction-memory word-address width (memory holds 2^IMEM_AW words)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_addr`  out  IMEM_AW  word address to instruction memory, = `pc[IMEM_AW+1:2]`
- `imem_data`  in  32  instruction word, combinational from `imem_addr`
- `stall`  in  1  hold PC and IF/ID
- `redirect`  in  1  load `redirect_pc`, squash fetched slot
- `redirect_pc`  in  32  byte target address
- `fetch_pc`  out  32  current PC
- `if_id_pc`  out  32  PC of instruction in IF/ID
- `if_id_pc4`  out  32  `if_id_pc + 4`
- `if_id_instr`  out  32  registered instruction
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  FSM in HALT
- `misalign_err`  out  1  sticky: a misaligned redirect target was received

## Operation
- FSM states RUN, HALT. Out-of-range = `pc[31:IMEM_AW+2] != 0`.
- Per edge, priority redirect > stall > advance:
  - redirect (regardless of stall or state): `pc <= {redirect_pc[31:2],2'b00}`; IF/ID <= bubble; state <= RUN; if `redirect_pc[1:0] != 0`, set `misalign_err`.
  - stall (no redirect): PC, IF/ID, state unchanged.
  - advance, RUN, in-range: IF/ID <= {pc, pc+4, imem_data, valid=1}; `pc <= pc+4`.
  - advance, RUN, out-of-range: IF/ID <= bubble; PC held; state <= HALT.
  - advance, HALT: IF/ID <= bubble; PC held.
- Bubble: `if_id_instr = 32'h0000_0013` (addi x0,x0,0), `if_id_valid = 0`, `if_id_pc` and `if_id_pc4` = 0.
- Arithmetic: `pc+4` modulo 2^32; wrap from 0xFFFF_FFFC to 0 goes through HALT, because that PC is already out of range.
- A redirect to an out-of-range target enters RUN. The next advancing edge enters HALT.
- `misalign_err` clears only on reset.

## Timing
- Reset, asynchronous assert: `pc = RESET_PC`, state RUN, `if_id_valid = 0`, `if_id_instr = 32'h13`, `if_id_pc = if_id_pc4 = 0`, `halted = 0`, `misalign_err = 0`. Deassertion is synchronised externally.
- `imem_addr` and `fetch_pc` follow the PC register combinationally. The instruction is captured on the same edge that advances the PC, so IF latency is 1 cycle.
- Redirect sampled at edge N: the target's instruction is in IF/ID after edge N+1. One bubble is inserted after edge N.
- Stall is effective on every edge while it is high. It carries no pending state, and the release is immediate.
- `halted` is a registered state output.

## Structure
- Package `rv32_pkg`:
  - `RV32_NOP = 32'h0000_0013`
  - fetch FSM enum `{FETCH_RUN, FETCH_HALT}`
  - default `RESET_PC`
- Sub-module `if_id_reg`: IF/ID register with load/hold/bubble controls and async reset to the bubble value.
- PC, next-PC logic and FSM stay in `rv32_fetch_stage`.

## Test plan
- Reset then 3 free-running cycles, with the imem model holding words 0..2 = 0x00002083, 0x00402103, 0x00802183:
  - fetch_pc steps 0 -> 4 -> 8 -> 0xC.
  - IF/ID shows (0, 4, 0x00002083) then (4, 8, 0x00402103), valid=1.
- Stall high for 2 cycles at pc=8: pc stays 8, IF/ID keeps (4, 0x00402103). After release it advances to (8, 0x00802183).
- Redirect to 0x10 with stall also high, at pc=0xC:
  - next edge: pc=0x10, IF/ID bubble (0x13, valid=0).
  - following edge: IF/ID holds pc 0x10 with word 4.
- Free-run to pc=0xFC then beyond:
  - word 63 latched at 0xFC.
  - at pc=0x100: bubble, halted=1, pc stays 0x100 over 5 cycles.
  - redirect to 0 clears halted and refetches word 0.
- Redirect to 0x16: pc=0x14, misalign_err=1. It stays 1 across later redirects until rst_n is asserted.
- Assert rst_n=0 mid-edge-cycle while pc=0x20 and IF/ID is valid: all outputs reach reset values immediately, without waiting for clk.
